// File: rtl/dnn_accel_pio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dnn_accel_pio_pkg : register map and edge-type encoding for the PIO |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package dnn_accel_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE    = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage
`default_nettype wire

// File: rtl/dnn_accel_pio_in_edge_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dnn_accel_pio_in_edge_if : Avalon-MM slave bus plus interrupt line  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface dnn_accel_pio_in_edge_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write, writedata,
    output readdata, irq
  );

endinterface
`default_nettype wire

// File: rtl/pio_debounce_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pio_debounce_bit : one-bit synchroniser plus stability debouncer    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module pio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_stable
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign o_stable = w_sync;
    end else begin : g_debounce
      localparam int               c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

      logic [c_cnt_w-1:0] r_cnt;
      logic               r_stable;

      // Counter runs only while sync disagrees; any agreement restarts the window.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (w_sync == r_stable) begin
          r_cnt    <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_stable <= w_sync;
          r_cnt    <= '0;
        end else begin
          r_cnt    <= r_cnt + c_cnt_w'(1);
        end
      end

      assign o_stable = r_stable;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dnn_accel_pio_in_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dnn_accel_pio_in_edge : debounced input port with edge capture/IRQ  |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module dnn_accel_pio_in_edge
  import dnn_accel_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      in_port,
  dnn_accel_pio_in_edge_if.slave bus
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [31:0]      w_rdata;
  logic [31:0]      r_readdata;
  logic             w_wr;
  logic             w_unused;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_debounce_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_async  (in_port[gi]),
        .o_stable (w_stable[gi])
      );
    end

    if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_fall
      assign w_edge = ~w_stable & r_prev;
    end else if (EDGE_TYPE == int'(EDGE_ANY)) begin : g_any
      assign w_edge = w_stable ^ r_prev;
    end else begin : g_rise
      assign w_edge = w_stable & ~r_prev;
    end
  endgenerate

  assign w_wr     = bus.chipselect & bus.write;
  assign w_clr    = (w_wr && bus.address == PIO_ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_unused = ^bus.writedata;

  // Clear is applied before the set so a coincident edge keeps its bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_edgecap  <= '0;
      r_irqmask  <= '0;
      r_readdata <= '0;
    end else begin
      r_prev     <= w_stable;
      r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
      r_readdata <= w_rdata;
      if (w_wr && bus.address == PIO_ADDR_IRQMASK) begin
        r_irqmask <= bus.writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      PIO_ADDR_DATA:    w_rdata = 32'(w_stable);
      PIO_ADDR_IRQMASK: w_rdata = 32'(r_irqmask);
      PIO_ADDR_EDGE:    w_rdata = 32'(r_edgecap);
      default:          w_rdata = '0;
    endcase
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edgecap & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_dnn_accel_pio_in_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dnn_accel_pio_in_edge : directed bench over three PIO configs    |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_dnn_accel_pio_in_edge;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] in_c;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  dnn_accel_pio_in_edge_if ifa ();
  dnn_accel_pio_in_edge_if ifb ();
  dnn_accel_pio_in_edge_if ifc ();

  // A: rising, no debounce.  B: rising, 4-cycle debounce.  C: any edge.
  dnn_accel_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0))
    u_dut_a (.clk(clk), .reset_n(reset_n), .in_port(in_a), .bus(ifa));
  dnn_accel_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0))
    u_dut_b (.clk(clk), .reset_n(reset_n), .in_port(in_b), .bus(ifb));
  dnn_accel_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2))
    u_dut_c (.clk(clk), .reset_n(reset_n), .in_port(in_c), .bus(ifc));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [31:0] d);
    ifa.address = a; ifa.chipselect = 1'b1; ifa.write = 1'b1; ifa.writedata = d;
    tick();
    ifa.chipselect = 1'b0; ifa.write = 1'b0; ifa.writedata = '0;
  endtask

  task automatic wr_c(input logic [1:0] a, input logic [31:0] d);
    ifc.address = a; ifc.chipselect = 1'b1; ifc.write = 1'b1; ifc.writedata = d;
    tick();
    ifc.chipselect = 1'b0; ifc.write = 1'b0; ifc.writedata = '0;
  endtask

  task automatic rd_a(input logic [1:0] a, output logic [31:0] d);
    ifa.address = a; tick(); d = ifa.readdata;
  endtask

  task automatic rd_b(input logic [1:0] a, output logic [31:0] d);
    ifb.address = a; tick(); d = ifb.readdata;
  endtask

  task automatic rd_c(input logic [1:0] a, output logic [31:0] d);
    ifc.address = a; tick(); d = ifc.readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset_n = 1'b0;
    in_a = 8'hA5; in_b = 8'h00; in_c = 8'h00;
    ifa.address = 2'd0; ifa.chipselect = 1'b0; ifa.write = 1'b0; ifa.writedata = '0;
    ifb.address = 2'd0; ifb.chipselect = 1'b0; ifb.write = 1'b0; ifb.writedata = '0;
    ifc.address = 2'd0; ifc.chipselect = 1'b0; ifc.write = 1'b0; ifc.writedata = '0;
    repeat (3) tick();
    n_tests++;
    if (ifa.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata: got %h want %h", ifa.readdata, 32'h0);
    end
    n_tests++;
    if (ifa.irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %b want 0", ifa.irq);
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_tests++;
      if (ifa.readdata !== ((e == 3) ? 32'h0000_00A5 : 32'h0)) begin
        n_fail++;
        $display("FAIL reset_release_edge%0d: got %h want %h", e, ifa.readdata,
                 (e == 3) ? 32'h0000_00A5 : 32'h0);
      end
    end
    rd_a(2'd3, d);
    n_tests++;
    if (d !== 32'h0000_00A5) begin
      n_fail++; $display("FAIL reset_rise_capture: got %h want %h", d, 32'h0000_00A5);
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    wr_a(2'd3, 32'hFF);
    wr_a(2'd2, 32'h1);
    rd_a(2'd2, d);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL irqmask_readback: got %h want %h", d, 32'h1);
    end
    n_tests++;
    if (ifa.irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_idle: got %b want 0", ifa.irq);
    end
    in_a = 8'hA4;
    repeat (4) tick();
    rd_a(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL falling_ignored: got %h want %h", d, 32'h0);
    end
    in_a = 8'hA5;
    tick(); tick();
    n_tests++;
    if (ifa.irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_early: got %b want 0", ifa.irq);
    end
    tick();
    n_tests++;
    if (ifa.irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_assert: got %b want 1", ifa.irq);
    end
    rd_a(2'd3, d);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL irq_capture: got %h want %h", d, 32'h1);
    end
    wr_a(2'd3, 32'h1);
    n_tests++;
    if (ifa.irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_clear: got %b want 0", ifa.irq);
    end
    rd_a(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL w1c_clear: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_w1c_collision;
    logic [31:0] d;
    in_a = 8'hA1;
    repeat (4) tick();
    wr_a(2'd3, 32'hFF);
    in_a = 8'hA5;
    tick(); tick();
    wr_a(2'd3, 32'h4);
    rd_a(2'd3, d);
    n_tests++;
    if (d !== 32'h4) begin
      n_fail++; $display("FAIL set_beats_clear: got %h want %h", d, 32'h4);
    end
    n_tests++;
    if (ifa.irq !== 1'b0) begin
      n_fail++; $display("FAIL collision_irq_masked: got %b want 0", ifa.irq);
    end
    wr_a(2'd3, 32'h4);
    rd_a(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL collision_later_clear: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_debounce;
    logic [31:0] d;
    ifb.address = 2'd0;
    in_b = 8'h01;
    repeat (3) tick();
    in_b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if (ifb.readdata !== 32'h0) begin
        n_fail++; $display("FAIL glitch_data_c%0d: got %h want %h", i, ifb.readdata, 32'h0);
      end
    end
    rd_b(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL glitch_capture: got %h want %h", d, 32'h0);
    end
    ifb.address = 2'd0;
    in_b = 8'h01;
    repeat (6) tick();
    n_tests++;
    if (ifb.readdata !== 32'h0) begin
      n_fail++; $display("FAIL debounce_early: got %h want %h", ifb.readdata, 32'h0);
    end
    tick();
    n_tests++;
    if (ifb.readdata !== 32'h1) begin
      n_fail++; $display("FAIL debounce_settle: got %h want %h", ifb.readdata, 32'h1);
    end
    rd_b(2'd3, d);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL debounce_capture: got %h want %h", d, 32'h1);
    end
  endtask

  task automatic test_any_edge;
    logic [31:0] d;
    in_c = 8'h80;
    repeat (5) tick();
    rd_c(2'd3, d);
    n_tests++;
    if (d !== 32'h80) begin
      n_fail++; $display("FAIL any_rise: got %h want %h", d, 32'h80);
    end
    wr_c(2'd3, 32'h80);
    rd_c(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL any_clear: got %h want %h", d, 32'h0);
    end
    in_c = 8'h00;
    repeat (5) tick();
    rd_c(2'd3, d);
    n_tests++;
    if (d !== 32'h80) begin
      n_fail++; $display("FAIL any_fall: got %h want %h", d, 32'h80);
    end
    wr_c(2'd0, 32'hFF);
    wr_c(2'd1, 32'hFF);
    rd_c(2'd1, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL rsvd_read: got %h want %h", d, 32'h0);
    end
    rd_c(2'd0, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL data_readonly: got %h want %h", d, 32'h0);
    end
    rd_c(2'd2, d);
    n_tests++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL mask_untouched: got %h want %h", d, 32'h0);
    end
    rd_c(2'd3, d);
    n_tests++;
    if (d !== 32'h80) begin
      n_fail++; $display("FAIL capture_untouched: got %h want %h", d, 32'h80);
    end
    n_tests++;
    if (ifc.irq !== 1'b0) begin
      n_fail++; $display("FAIL any_irq_unmasked: got %b want 0", ifc.irq);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_irq();
    test_w1c_collision();
    test_debounce();
    test_any_edge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dnn_accel_pio_in_edge.md
# dnn_accel_pio_in_edge

Parametrised Avalon-MM input port for the DNN accelerator system: synchronises and debounces a WIDTH-bit external input bus, latches configurable edge events into a sticky capture register and raises a maskable level interrupt. It sits on the system interconnect as a 4-word slave and supersedes the fixed 8-bit read-only switch port. Software reads the data, programs the IRQ mask and clears edge-capture bits.

## Interface
- WIDTH, 8: input bus width, 1..32
- SYNC_STAGES, 2: synchroniser flops per bit, ≥2
- DEBOUNCE_CYCLES, 0: stability window in clk cycles; 0 = debouncer bypassed
- EDGE_TYPE, 0: 0 = rising, 1 = falling, 2 = any edge
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  word address
- chipselect  in  1  slave select
- write  in  1  write strobe, qualified by chipselect
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt

## Operation
- Reset: reset_n asynchronous, active-low; clock clk. On reset, all synchroniser, debounce, stable, previous-value, edgecapture and irqmask registers clear to 0; readdata = 0; irq = 0.
- Synchroniser: each in_port bit passes through SYNC_STAGES flops; the last stage is sync.
- Debounce (DEBOUNCE_CYCLES = D > 0), per bit:
  - Counter width is clog2(D+1).
  - sync == stable: counter <= 0.
  - sync != stable and counter == D-1: stable <= sync, counter <= 0.
  - Otherwise counter increments.
  - Any reversion before D consecutive mismatching cycles discards the change.
- D = 0: stable = sync (wire).
- Edge detect: prev <= stable every cycle.
  - Rising edge = stable & ~prev.
  - Falling edge = ~stable & prev.
  - Any edge = the XOR of stable and prev.
- Edgecapture, per bit:
  - Set on a detected edge.
  - Cleared by a write to address 3 with writedata bit = 1 (write-1-to-clear).
  - Simultaneous edge and clear on the same bit: set wins.
  - Bits ≥ WIDTH read 0.
- Register map:
  - 0: data = stable, zero-extended; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2: irqmask, R/W, bits [WIDTH-1:0].
  - 3: edgecapture, read / W1C.
- irq = OR of (edgecapture & irqmask), combinational from registers.
- readdata: registered every cycle from the address mux, independent of chipselect.

## Timing
- Read latency: 1 cycle. Address presented before edge k → readdata valid after edge k.
- in_port change sampled at edge 1:
  - stable updates at edge SYNC_STAGES + D.
  - readdata (address 0) shows the new value after edge SYNC_STAGES + D + 1.
  - edgecapture sets at edge SYNC_STAGES + D + 1.
  - irq asserts in the same cycle if the bit is masked in.
- Write to irqmask or edgecapture takes effect at the write edge; irq follows in the same cycle.
- Reset mid-debounce: counters clear; no edge is generated on reset release unless the input differs from 0 for D cycles after synchronisation.

## Structure
- Shared package dnn_accel_pio_pkg:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_RSVD=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGE=3
  - edge-type enum EDGE_RISE/EDGE_FALL/EDGE_ANY
- Sub-module pio_debounce_bit: synchroniser plus debounce counter for one bit, instantiated WIDTH times in a generate loop. Top level holds edge logic, registers, read mux and irq.

## Test plan
- Reset with in_port=8'hA5 held, then release, D=0, SYNC_STAGES=2 → readdata at address 0 reads 0 until edge 3, then 32'h000000A5. Rising-edge capture = 8'hA5.
- D=4: bit0 pulses high for 3 cycles → data and edgecapture unchanged. Bit0 held high 4 cycles → data bit0=1 at edge SYNC_STAGES+4+1.
- irqmask=8'h01, rising edge on bit0 → irq=1. Write 32'h1 to address 3 → edgecapture=0 and irq=0 the next cycle.
- Edge on bit2 in the same cycle as a W1C of bit2 → edgecapture bit2 remains 1.
- EDGE_TYPE=2, bit7 toggles 1→0 → edgecapture=8'h80. Write to address 0 or 1 → no register change; address 1 reads 0.
